// File: rtl/quad_knob_position_if.sv
// quad_knob_position_if: raw Pmod ENC pins in, bounded position out
interface quad_knob_position_if;
   logic [3:0] enc;
   logic [7:0] pos;
   logic       stepPulse;
   logic       dir;
   modport master (output enc, input pos, stepPulse, dir);
   modport slave  (input enc, output pos, stepPulse, dir);
endinterface

// File: rtl/quad_knob_position.sv
// quad_knob_position: synchronised, debounced quadrature encoder to a bounded 8-bit position
module quad_knob_position #(
   parameter int          MAX        = 159,
   parameter int          PRESET     = 0,
   parameter int          WRAP       = 1,
   parameter int          FAST_STEP  = 4,
   parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
   input logic clk,
   input logic rstN,
   quad_knob_position_if.slave io
);
   typedef enum logic [2:0] {REST, CW1, CW2, CW3, CCW1, CCW2, CCW3, IDLE_WAIT} state_t;
   logic [3:0]       s1_q, s2_q, deb_q, deb_d;
   logic [3:0][15:0] cnt_q, cnt_d;
   logic             btn_q, btn_rise, up, dn, pulse_q, dir_q, dir_d;
   logic [1:0]       ab;
   logic [8:0]       step, sum, dif;
   logic [7:0]       nxt, pos_q, pos_d;
   state_t           st_q, st_d;
   always_ff @(posedge clk or negedge rstN)
      if (!rstN) begin
         s1_q    <= 4'b0011;
         s2_q    <= 4'b0011;
         deb_q   <= 4'b0011;
         cnt_q   <= '0;
         btn_q   <= 1'b0;
         st_q    <= REST;
         pos_q   <= 8'(PRESET);
         pulse_q <= 1'b0;
         dir_q   <= 1'b1;
      end else begin
         s1_q    <= io.enc;
         s2_q    <= s1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         btn_q   <= deb_q[2];
         st_q    <= st_d;
         pos_q   <= pos_d;
         pulse_q <= pos_d != pos_q;
         dir_q   <= dir_d;
      end
   // a bit flips on the DEB_CYCLES-th consecutive cycle of disagreement
   always_comb
      for (int k = 0; k < 4; k++) begin
         cnt_d[k] = (s2_q[k] == deb_q[k] || cnt_q[k] == DEB_CYCLES - 16'd1) ? 16'd0 : cnt_q[k] + 16'd1;
         deb_d[k] = (s2_q[k] != deb_q[k] && cnt_q[k] == DEB_CYCLES - 16'd1) ? s2_q[k] : deb_q[k];
      end
   assign ab = {deb_q[0], deb_q[1]};
   always_comb begin
      st_d = st_q;
      up   = 1'b0;
      dn   = 1'b0;
      case (st_q)
         REST: st_d = ab == 2'b01 ? CW1 : ab == 2'b10 ? CCW1 : ab == 2'b00 ? IDLE_WAIT : REST;
         CW1:  st_d = ab == 2'b00 ? CW2 : ab == 2'b11 ? REST : ab == 2'b10 ? IDLE_WAIT : CW1;
         CW2:  st_d = ab == 2'b10 ? CW3 : ab == 2'b01 ? CW1 : ab == 2'b11 ? REST : CW2;
         CW3: begin
            st_d = ab == 2'b11 ? REST : ab == 2'b00 ? CW2 : ab == 2'b01 ? IDLE_WAIT : CW3;
            up   = ab == 2'b11;
         end
         CCW1: st_d = ab == 2'b00 ? CCW2 : ab == 2'b11 ? REST : ab == 2'b01 ? IDLE_WAIT : CCW1;
         CCW2: st_d = ab == 2'b01 ? CCW3 : ab == 2'b10 ? CCW1 : ab == 2'b11 ? REST : CCW2;
         CCW3: begin
            st_d = ab == 2'b11 ? REST : ab == 2'b00 ? CCW2 : ab == 2'b10 ? IDLE_WAIT : CCW3;
            dn   = ab == 2'b11;
         end
         default: st_d = ab == 2'b11 ? REST : IDLE_WAIT;
      endcase
   end
   // 9-bit arithmetic so the up-overflow and down-underflow cases are visible
   always_comb begin
      step     = deb_q[3] ? 9'(FAST_STEP) : 9'd1;
      sum      = {1'b0, pos_q} + step;
      dif      = {1'b0, pos_q} - step;
      nxt      = 8'(up ? (sum > 9'(MAX) ? (WRAP != 0 ? sum - 9'(MAX + 1) : 9'(MAX)) : sum)
                       : ({1'b0, pos_q} < step ? (WRAP != 0 ? dif + 9'(MAX + 1) : 9'd0) : dif));
      btn_rise = deb_q[2] & ~btn_q;
      pos_d    = btn_rise ? 8'(PRESET) : (up | dn) ? nxt : pos_q;
      dir_d    = (!btn_rise && (up | dn)) ? up : dir_q;
   end
   assign io.pos       = pos_q;
   assign io.stepPulse = pulse_q;
   assign io.dir       = dir_q;
endmodule

// File: tb/tb_quad_knob_position.sv
// tb_quad_knob_position: three instances (wrap/saturate/preset variants) against a queue scoreboard
module tb_quad_knob_position;
   typedef struct packed {logic [7:0] p; logic d;} exp_t;
   logic clk = 1'b0, rstN = 1'b0;
   logic a = 1'b1, b = 1'b1, btn = 1'b0, swt = 1'b0;
   logic [3:0] enc;
   logic [7:0] pa [3];
   logic spa [3], da [3];
   exp_t sbq [3][$];
   int vectors = 0, miscompares = 0;
   int mpos [3], mdir [3];
   int pre [3] = '{0, 157, 157};
   int wr [3] = '{1, 0, 1};
   always #5 clk = ~clk;
   assign enc = {swt, btn, b, a};
   quad_knob_position_if k0 (), k1 (), k2 ();
   assign k0.enc = enc;
   assign k1.enc = enc;
   assign k2.enc = enc;
   assign pa[0] = k0.pos; assign spa[0] = k0.stepPulse; assign da[0] = k0.dir;
   assign pa[1] = k1.pos; assign spa[1] = k1.stepPulse; assign da[1] = k1.dir;
   assign pa[2] = k2.pos; assign spa[2] = k2.stepPulse; assign da[2] = k2.dir;
   quad_knob_position #(.DEB_CYCLES(16'd4)) u0 (.clk(clk), .rstN(rstN), .io(k0));
   quad_knob_position #(.PRESET(157), .WRAP(0), .DEB_CYCLES(16'd4)) u1 (.clk(clk), .rstN(rstN), .io(k1));
   quad_knob_position #(.PRESET(157), .WRAP(1), .DEB_CYCLES(16'd4)) u2 (.clk(clk), .rstN(rstN), .io(k2));

   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 3; i++)
         if (spa[i] === 1'b1) begin
            vectors++;
            if (sbq[i].size() == 0) begin
               miscompares++;
               $display("FAIL pulse%0d: unexpected stepPulse, pos=%0d", i, pa[i]);
            end else begin
               e = sbq[i].pop_front();
               if (pa[i] !== e.p || da[i] !== e.d) begin
                  miscompares++;
                  $display("FAIL pulse%0d: pos/dir got %0d/%0d required %0d/%0d", i, pa[i], da[i], e.p, e.d);
               end
            end
         end
   end

   task automatic chk(string nm, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   function automatic int nxt(int p, bit up, int st, int wrap);
      if (wrap != 0) return up ? (p + st) % 160 : (p - st + 160) % 160;
      return up ? ((p + st > 159) ? 159 : p + st) : ((p - st < 0) ? 0 : p - st);
   endfunction

   task automatic step_model(bit up);
      exp_t e;
      int np;
      for (int i = 0; i < 3; i++) begin
         np = nxt(mpos[i], up, swt ? 4 : 1, wr[i]);
         e.p = 8'(np);
         e.d = up;
         if (np != mpos[i]) sbq[i].push_back(e);
         mpos[i] = np;
         mdir[i] = up;
      end
   endtask

   task automatic btn_model();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         e.p = 8'(pre[i]);
         e.d = mdir[i][0];
         if (mpos[i] != pre[i]) sbq[i].push_back(e);
         mpos[i] = pre[i];
      end
   endtask

   task automatic apply(logic na, logic nb);
      a = na;
      b = nb;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic cw(bit with_btn);
      apply(0, 1);
      apply(0, 0);
      apply(1, 0);
      if (with_btn) begin
         btn_model();
         btn = 1'b1;
      end else step_model(1);
      apply(1, 1);
   endtask

   task automatic ccw();
      apply(1, 0);
      apply(0, 0);
      apply(0, 1);
      step_model(0);
      apply(1, 1);
   endtask

   task automatic settle(string nm);
      repeat (4) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s.pending%0d", nm, i), sbq[i].size(), 0);
         chk($sformatf("%s.pos%0d", nm, i), int'(pa[i]), mpos[i]);
         chk($sformatf("%s.dir%0d", nm, i), int'(da[i]), mdir[i]);
         sbq[i].delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse(string nm);
      rstN = 1'b0;
      #2;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s.rpos%0d", nm, i), int'(pa[i]), pre[i]);
         chk($sformatf("%s.rdir%0d", nm, i), int'(da[i]), 1);
         chk($sformatf("%s.rpulse%0d", nm, i), int'(spa[i]), 0);
         mpos[i] = pre[i];
         mdir[i] = 1;
         sbq[i].delete();
      end
      @(posedge clk);
      #1;
      rstN = 1'b1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_pulse("t1");
      cw(0);
      settle("t1");
      chk("t1.lit_pos", int'(pa[0]), 1);
      rst_pulse("t2");
      ccw();
      settle("t2a");
      chk("t2.lit_pos", int'(pa[0]), 159);
      chk("t2.lit_dir", int'(da[0]), 0);
      cw(0);
      cw(0);
      settle("t2b");
      chk("t2.lit_pos2", int'(pa[0]), 1);
      rst_pulse("t3");
      swt = 1'b1;
      apply(1, 1);
      cw(0);
      settle("t3a");
      chk("t3.sat_pos", int'(pa[1]), 159);
      chk("t3.wrap_pos", int'(pa[2]), 1);
      cw(0);
      settle("t3b");
      chk("t3.sat_hold", int'(pa[1]), 159);
      chk("t3.sat_dir", int'(da[1]), 1);
      swt = 1'b0;
      apply(1, 1);
      rst_pulse("t4");
      a = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      apply(1, 1);
      settle("t4.glitch");
      apply(0, 1);
      apply(1, 1);
      settle("t4.abandon");
      apply(0, 0);
      apply(1, 1);
      settle("t4.illegal");
      cw(0);
      settle("t4.clean");
      chk("t4.lit_pos", int'(pa[0]), 1);
      rst_pulse("t5");
      swt = 1'b1;
      apply(1, 1);
      repeat (5) cw(0);
      settle("t5a");
      chk("t5.lit_pos20", int'(pa[0]), 20);
      cw(1);
      repeat (3) apply(1, 1);
      settle("t5b");
      chk("t5.lit_preset", int'(pa[0]), 0);
      chk("t5.lit_dir", int'(da[0]), 1);
      btn = 1'b0;
      swt = 1'b0;
      apply(1, 1);
      settle("t5c");
      apply(0, 1);
      apply(0, 0);
      rst_pulse("t6");
      apply(1, 0);
      apply(1, 1);
      settle("t6");
      chk("t6.lit_pos", int'(pa[0]), 0);
      repeat (40) begin
         case ($urandom_range(0, 7))
            0, 1: cw(0);
            2, 3: ccw();
            4: begin swt = ~swt; apply(1, 1); end
            5: begin apply(1, 0); apply(0, 0); apply(1, 0); apply(1, 1); end
            6: begin btn = 1'b1; btn_model(); apply(1, 1); btn = 1'b0; apply(1, 1); end
            default: begin cw(1); btn = 1'b0; apply(1, 1); end
         endcase
         settle("rnd");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
